rr_arb4_mux: RTL and testbench

Round-robin arbiter and output register that sit directly upstream of `mux4to1`. The arbiter chooses one of four valid/ready input channels and drives the 2-bit select (`S`) of an internal `mux4to1` instance. The selected N-bit word is registered into a single output stage with a valid/ready handshake. The block turns the combinational 4:1 mux into a flow-controlled 4-to-1 funnel for downstream consumers.

---
 rtl/rr_arb_pkg.sv | 52 +++++
 rtl/rr_arb4_mux_mux4to1.sv | 24 ++
 rtl/rr_arb4_mux.sv | 142 ++++++++++++++
 tb/tb_rr_arb4_mux.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/rr_arb_pkg.sv
// Shared types, constants and winner-selection helpers for the 4-channel
// round-robin arbiter in front of mux4to1.
package rr_arb_pkg;

    localparam int CH_NUM = 4;
    localparam int SEL_W  = 2;

    typedef logic [SEL_W-1:0] ch_sel_t;

    // Output register occupancy: EMPTY has no word, FULL holds an unconsumed word.
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_e;

    // Round-robin pick: search from last+1 upward with wrap, first valid wins.
    // With no valid bit the result is unused, so last+1 is returned.
    function automatic ch_sel_t rr_pick(input logic [CH_NUM-1:0] valid,
                                        input ch_sel_t           last);
        ch_sel_t pick;
        ch_sel_t idx;
        logic    found;
        pick  = last + 2'd1;
        found = 1'b0;
        for (int i = 1; i <= CH_NUM; i++) begin
            idx = last + ch_sel_t'(i);
            if (!found && valid[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    // Fixed priority pick: lowest valid index wins (A highest).
    function automatic ch_sel_t fixed_pick(input logic [CH_NUM-1:0] valid);
        ch_sel_t pick;
        pick = 2'd0;
        for (int i = CH_NUM - 1; i >= 0; i--) begin
            if (valid[i]) begin
                pick = ch_sel_t'(i);
            end
        end
        return pick;
    endfunction

    // One-hot decode of a channel index.
    function automatic logic [CH_NUM-1:0] sel_onehot(input ch_sel_t sel);
        return 4'b0001 << sel;
    endfunction

endpackage

// File: rtl/rr_arb4_mux_mux4to1.sv
// Plain combinational 4:1 word multiplexer; S selects A..D.
module mux4to1 #(
    parameter int N = 4
) (
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic [N-1:0] C,
    input  logic [N-1:0] D,
    input  logic [1:0]   S,
    output logic [N-1:0] Z
);

    // Route the selected channel word to Z.
    always_comb begin
        case (S)
            2'd0:    Z = A;
            2'd1:    Z = B;
            2'd2:    Z = C;
            2'd3:    Z = D;
            default: Z = {N{1'b0}};
        endcase
    end

endmodule

// File: rtl/rr_arb4_mux.sv
// Round-robin 4-to-1 funnel: arbitrates four valid/ready channels, drives the
// select of a mux4to1 instance and registers the chosen word into a single
// output stage with valid/ready flow control.
// Build option: define RR_ARB_FIXED_PRIO_EN for fixed priority (A highest);
// the default build uses round-robin starting after the last winner.
module rr_arb4_mux
    import rr_arb_pkg::*;
#(
    parameter int N = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [CH_NUM-1:0] in_valid,
    output logic [CH_NUM-1:0] in_ready,
    input  logic [N-1:0]      A,
    input  logic [N-1:0]      B,
    input  logic [N-1:0]      C,
    input  logic [N-1:0]      D,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N-1:0]      out_data,
    output logic [SEL_W-1:0]  out_sel,
    output logic [CH_NUM-1:0] grant
);

    out_state_e        state_q, state_d;
    logic [N-1:0]      data_q, data_d;
    ch_sel_t           sel_q, sel_d;
    logic [CH_NUM-1:0] grant_q, grant_d;
`ifndef RR_ARB_FIXED_PRIO_EN
    ch_sel_t           last_q, last_d;
`endif

    ch_sel_t           winner_s;
    logic              accept_s;
    logic [N-1:0]      mux_z_s;
    logic              full_s;

    assign full_s = (state_q == ST_FULL);

    // Winner selection; only the valid vector and the priority pointer matter.
    always_comb begin
`ifdef RR_ARB_FIXED_PRIO_EN
        winner_s = fixed_pick(in_valid);
`else
        winner_s = rr_pick(in_valid, last_q);
`endif
    end

    // Accept when something is offered and the output slot is free or draining;
    // reset blocks acceptance so a reset cycle never moves a word.
    always_comb begin
        accept_s = (in_valid != 4'b0000) && (!full_s || out_ready) && !reset;
        if (accept_s) begin
            in_ready = sel_onehot(winner_s);
        end else begin
            in_ready = 4'b0000;
        end
    end

    mux4to1 #(.N(N)) u_mux (
        .A (A),
        .B (B),
        .C (C),
        .D (D),
        .S (winner_s),
        .Z (mux_z_s)
    );

    // Next-state logic for the output stage: load on accept, drop on drain, else hold.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        sel_d   = sel_q;
        grant_d = grant_q;
`ifndef RR_ARB_FIXED_PRIO_EN
        last_d  = last_q;
`endif
        case (state_q)
            ST_EMPTY: begin
                if (accept_s) begin
                    state_d = ST_FULL;
                    data_d  = mux_z_s;
                    sel_d   = winner_s;
                    grant_d = sel_onehot(winner_s);
`ifndef RR_ARB_FIXED_PRIO_EN
                    last_d  = winner_s;
`endif
                end else begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (accept_s) begin
                    state_d = ST_FULL;
                    data_d  = mux_z_s;
                    sel_d   = winner_s;
                    grant_d = sel_onehot(winner_s);
`ifndef RR_ARB_FIXED_PRIO_EN
                    last_d  = winner_s;
`endif
                end else if (out_ready) begin
                    state_d = ST_EMPTY;
                    grant_d = 4'b0000;
                end else begin
                    state_d = ST_FULL;
                end
            end
            default: begin
                state_d = ST_EMPTY;
                grant_d = 4'b0000;
            end
        endcase
    end

    // Output stage and priority pointer registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_EMPTY;
            data_q  <= {N{1'b0}};
            sel_q   <= 2'd0;
            grant_q <= 4'b0000;
`ifndef RR_ARB_FIXED_PRIO_EN
            last_q  <= 2'd3;
`endif
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
            grant_q <= grant_d;
`ifndef RR_ARB_FIXED_PRIO_EN
            last_q  <= last_d;
`endif
        end
    end

    assign out_valid = full_s;
    assign out_data  = data_q;
    assign out_sel   = sel_q;
    assign grant     = grant_q;

endmodule

// File: tb/tb_rr_arb4_mux.sv
// Directed bench for rr_arb4_mux: reset, single channel, fairness rotation,
// backpressure, drain, idle-channel skipping and mid-stream reset.
module tb_rr_arb4_mux;

    logic       clk;
    logic       reset;
    logic [3:0] in_valid;
    logic [3:0] in_ready;
    logic [3:0] A, B, C, D;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_data;
    logic [1:0] out_sel;
    logic [3:0] grant;

    int vec_cnt;
    int err_cnt;

    rr_arb4_mux #(.N(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .C         (C),
        .D         (D),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .grant     (grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    logic [1:0] rot_sel  [8] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
    logic [3:0] rot_data [8] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001,
                                 4'b1000, 4'b0100, 4'b0010, 4'b0001};

    initial begin
        vec_cnt   = 0;
        err_cnt   = 0;
        reset     = 1'b1;
        in_valid  = 4'b0000;
        out_ready = 1'b1;
        A = 4'b1000;
        B = 4'b0100;
        C = 4'b0010;
        D = 4'b0001;

        tick();
        tick();
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data",  {28'd0, out_data},  32'd0);
        chk("rst_out_sel",   {30'd0, out_sel},   32'd0);
        chk("rst_grant",     {28'd0, grant},     32'd0);
        chk("rst_in_ready",  {28'd0, in_ready},  32'd0);

`ifdef RR_ARB_FIXED_PRIO_EN
        @(negedge clk);
        in_valid = 4'b1111;
        #1;
        chk("fp_in_ready", {28'd0, in_ready}, 32'h1);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("fp_sel",  {30'd0, out_sel},  32'd0);
            chk("fp_data", {28'd0, out_data}, 32'h8);
        end
        @(negedge clk);
        in_valid = 4'b1001;
        #1;
        chk("fp_1001_ready", {28'd0, in_ready}, 32'h1);
        @(negedge clk);
        in_valid = 4'b1000;
        #1;
        chk("fp_d_ready", {28'd0, in_ready}, 32'h8);
        tick();
        chk("fp_d_sel", {30'd0, out_sel}, 32'd3);
`else
        // Single channel C after reset.
        @(negedge clk);
        in_valid = 4'b0100;
        #1;
        chk("single_in_ready", {28'd0, in_ready}, 32'h4);
        tick();
        chk("single_valid", {31'd0, out_valid}, 32'd1);
        chk("single_data",  {28'd0, out_data},  32'h2);
        chk("single_sel",   {30'd0, out_sel},   32'd2);
        chk("single_grant", {28'd0, grant},     32'h4);

        // Reset while FULL: word discarded, no acceptance during reset.
        @(negedge clk);
        reset    = 1'b1;
        in_valid = 4'b1111;
        #1;
        chk("midrst_in_ready", {28'd0, in_ready}, 32'h0);
        tick();
        chk("midrst_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_grant", {28'd0, grant},     32'h0);
        chk("midrst_data",  {28'd0, out_data},  32'h0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midrst_next_a", {28'd0, in_ready}, 32'h1);

        // All valid with out_ready: strict A,B,C,D rotation.
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("rot_sel",   {30'd0, out_sel},   {30'd0, rot_sel[k]});
            chk("rot_data",  {28'd0, out_data},  {28'd0, rot_data[k]});
            chk("rot_valid", {31'd0, out_valid}, 32'd1);
        end
        tick();
        chk("rot_wrap_data", {28'd0, out_data}, 32'h8);

        // Backpressure while holding A's word.
        @(negedge clk);
        out_ready = 1'b0;
        #1;
        chk("stall_in_ready", {28'd0, in_ready}, 32'h0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("stall_data",  {28'd0, out_data},  32'h8);
            chk("stall_valid", {31'd0, out_valid}, 32'd1);
            chk("stall_grant", {28'd0, grant},     32'h1);
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        chk("unstall_ready_b", {28'd0, in_ready}, 32'h2);
        tick();
        chk("unstall_sel",  {30'd0, out_sel},  32'd1);
        chk("unstall_data", {28'd0, out_data}, 32'h4);

        // Drain with no input: valid and grant drop, data/sel held.
        @(negedge clk);
        in_valid = 4'b0000;
        tick();
        chk("drain_valid", {31'd0, out_valid}, 32'd0);
        chk("drain_grant", {28'd0, grant},     32'h0);
        chk("drain_data",  {28'd0, out_data},  32'h4);
        chk("drain_sel",   {30'd0, out_sel},   32'd1);
        tick();

        // Idle cycles must not rotate priority: after B, C beats A.
        @(negedge clk);
        in_valid = 4'b0101;
        #1;
        chk("idle_norot_ready", {28'd0, in_ready}, 32'h4);
        tick();
        chk("idle_norot_sel", {30'd0, out_sel}, 32'd2);

        // Search after C: D idle, A wins.
        @(negedge clk);
        in_valid = 4'b0001;
        tick();
        chk("wrap_a_sel", {30'd0, out_sel}, 32'd0);

        // last=A with A and D valid: B, C skipped, D wins before A.
        @(negedge clk);
        in_valid = 4'b1001;
        #1;
        chk("skip_ready_d", {28'd0, in_ready}, 32'h8);
        tick();
        chk("skip_sel_d",  {30'd0, out_sel},  32'd3);
        chk("skip_data_d", {28'd0, out_data}, 32'h1);
        @(negedge clk);
        #1;
        chk("skip_ready_a", {28'd0, in_ready}, 32'h1);
        tick();
        chk("skip_sel_a", {30'd0, out_sel}, 32'd0);

        @(negedge clk);
        in_valid = 4'b0000;
        tick();
        chk("final_valid", {31'd0, out_valid}, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
